// File: rtl/led_pkg.sv
// Mode constants, scheduler state encoding and playlist helper shared with the animation top.
package led_pkg;

  localparam logic [1:0] MODE_SHIFT = 2'd0;
  localparam logic [1:0] MODE_FILL  = 2'd1;
  localparam logic [1:0] MODE_PWM   = 2'd2;
  localparam logic [1:0] MODE_OFF   = 2'd3;

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_e;

  function automatic logic [1:0] seq_mode(input logic [7:0] seq, input logic [1:0] i);
    return seq[2*i +: 2];
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divide-by-DIV counter; tick is the terminal count of the current cycle.
module tick_prescaler #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  // Combinational so the scheduler can act on the wrap in the same edge.
  assign tick = en && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clr)  cnt <= '0;
    else if (en)     cnt <= tick ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/led_mode_scheduler.sv
// Playlist controller: steps the animation mode through MODE_SEQ with dwell time and blanking gaps.
module led_mode_scheduler
  import led_pkg::*;
#(
  parameter int         TICK_DIV  = 1000,
  parameter int         DWELL_W   = 8,
  parameter int         SEQ_LEN   = 4,
  parameter logic [7:0] MODE_SEQ  = 8'b00_10_01_00,
  parameter int         GAP_TICKS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               pause,
  input  logic               skip,
  input  logic [DWELL_W-1:0] dwell,
  output logic [1:0]         mode,
  output logic [1:0]         idx,
  output logic               tick,
  output logic               entry_done,
  output logic               busy
);

  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  state_e             state;
  logic [DWELL_W-1:0] dwell_lat, dwell_cnt, dwell_eff;
  logic [GW-1:0]      gap_cnt;
  logic [1:0]         nxt_idx;
  logic               tc, en, clr, end_show, end_gap;

  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign nxt_idx   = (idx == 2'(SEQ_LEN - 1)) ? 2'd0 : idx + 2'd1;
  assign en        = run && (state != IDLE) && !pause;
  // skip ends the entry even while paused
  assign end_show  = (state == SHOW) && (skip || (tc && dwell_cnt == dwell_lat - 1'b1));
  assign end_gap   = (state == GAP) && tc && (gap_cnt == GW'(GAP_TICKS - 1));
  assign clr       = (state == IDLE) || !run || end_show || end_gap;

  tick_prescaler #(.DIV(TICK_DIV)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (en),
    .tick (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mode       <= MODE_OFF;
      idx        <= 2'd0;
      tick       <= 1'b0;
      entry_done <= 1'b0;
      busy       <= 1'b0;
      dwell_lat  <= '0;
      dwell_cnt  <= '0;
      gap_cnt    <= '0;
    end else begin
      tick       <= tc;
      entry_done <= 1'b0;
      if (!run) begin
        state     <= IDLE;
        mode      <= MODE_OFF;
        idx       <= 2'd0;
        busy      <= 1'b0;
        dwell_cnt <= '0;
        gap_cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            state     <= SHOW;
            idx       <= 2'd0;
            mode      <= seq_mode(MODE_SEQ, 2'd0);
            busy      <= 1'b1;
            dwell_lat <= dwell_eff;
            dwell_cnt <= '0;
          end
          SHOW: begin
            if (end_show) begin
              entry_done <= 1'b1;
              if (GAP_TICKS == 0) begin
                idx       <= nxt_idx;
                mode      <= seq_mode(MODE_SEQ, nxt_idx);
                dwell_lat <= dwell_eff;
                dwell_cnt <= '0;
              end else begin
                state   <= GAP;
                mode    <= MODE_OFF;
                gap_cnt <= '0;
              end
            end else if (tc) begin
              dwell_cnt <= dwell_cnt + 1'b1;
            end
          end
          GAP: begin
            if (end_gap) begin
              state     <= SHOW;
              idx       <= nxt_idx;
              mode      <= seq_mode(MODE_SEQ, nxt_idx);
              dwell_lat <= dwell_eff;
              dwell_cnt <= '0;
            end else if (tc) begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            mode  <= MODE_OFF;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_mode_scheduler.sv
// Bench: cycle-count reference model of the playlist plus directed scenarios and random stimulus.
module tb_led_mode_scheduler;

  localparam int         TD  = 4;
  localparam int         GT  = 2;
  localparam int         SL  = 4;
  localparam logic [7:0] SEQ = 8'b00_10_01_00;

  logic       clk = 1'b0;
  logic       rst, run, pause, skip;
  logic [7:0] dwell;
  logic [1:0] mode, idx;
  logic       tick, entry_done, busy;

  always #5 clk = ~clk;

  led_mode_scheduler #(
    .TICK_DIV(TD), .DWELL_W(8), .SEQ_LEN(SL), .MODE_SEQ(SEQ), .GAP_TICKS(GT)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .pause(pause), .skip(skip), .dwell(dwell),
    .mode(mode), .idx(idx), .tick(tick), .entry_done(entry_done), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: phase 0 idle / 1 show / 2 gap, with remaining active cycles and elapsed active cycles.
  int   m_st = 0, m_idx = 0, m_left = 0, m_el = 0;
  logic m_tick = 1'b0, m_done = 1'b0;
  bit   live = 1'b0;

  function automatic int exp_mode(input int st, input int ix);
    int s;
    s = SEQ;
    return (st == 1) ? ((s >> (2 * ix)) & 3) : 3;
  endfunction

  always @(posedge clk) begin
    automatic int   st = m_st, ix = m_idx, lf = m_left, el = m_el;
    automatic logic tk = 1'b0, dn = 1'b0;
    automatic int   d = (dwell == 0) ? 1 : int'(dwell);
    if (rst) begin
      st = 0; ix = 0; lf = 0; el = 0;
    end else if (!run) begin
      st = 0; ix = 0;
    end else if (st == 0) begin
      st = 1; ix = 0; lf = d * TD; el = 0;
    end else begin
      if (!pause) begin
        el++; lf--;
        tk = (el % TD == 0);
      end
      if (st == 1 && (skip || lf == 0)) begin
        dn = 1'b1; st = 2; lf = GT * TD; el = 0;
      end else if (st == 2 && lf == 0) begin
        st = 1; ix = (ix + 1) % SL; lf = d * TD; el = 0;
      end
    end
    m_st <= st; m_idx <= ix; m_left <= lf; m_el <= el;
    m_tick <= tk; m_done <= dn;
    live <= 1'b1;
  end

  always @(negedge clk) begin
    if (live) begin
      chk("mdl_mode", mode, exp_mode(m_st, m_idx));
      chk("mdl_idx", idx, m_idx);
      chk("mdl_busy", busy, (m_st != 0) ? 1 : 0);
      chk("mdl_tick", tick, m_tick);
      chk("mdl_done", entry_done, m_done);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; pause = 1'b0; skip = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int exp_seq[9] = '{0, 3, 1, 3, 2, 3, 0, 3, 0};
  int seen[$];

  initial begin
    rst = 1'b1; run = 1'b0; pause = 1'b0; skip = 1'b0; dwell = 8'd3;

    // basic timing and a full playlist loop
    do_reset();
    chk("rst_mode", mode, 3); chk("rst_idx", idx, 0); chk("rst_busy", busy, 0);
    chk("rst_tick", tick, 0); chk("rst_done", entry_done, 0);
    dwell = 8'd3; run = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1)  begin chk("first_mode", mode, 0); chk("first_busy", busy, 1); end
      if (k == 12) chk("show_end_mode", mode, 0);
      if (k == 13) begin chk("gap_mode", mode, 3); chk("gap_done", entry_done, 1); end
      if (k == 21) begin chk("e1_mode", mode, 1); chk("e1_idx", idx, 1); end
      if (k == 61) chk("e3_idx", idx, 3);
      if (k == 81) chk("wrap_idx", idx, 0);
      if (k == 1 || (seen.size() > 0 && int'(mode) != seen[seen.size()-1])) seen.push_back(int'(mode));
    end
    for (int i = 0; i < 9; i++)
      chk("loop_seq", (i < seen.size()) ? seen[i] : -1, exp_seq[i]);

    // pause for 5 cycles inside SHOW
    do_reset();
    dwell = 8'd3; run = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k >= 6 && k <= 11) chk("pause_tick", tick, 0);
      if (k == 17) chk("pause_show", mode, 0);
      if (k == 18) begin chk("pause_gap", mode, 3); chk("pause_done", entry_done, 1); end
      pause = (k >= 5 && k < 10);
    end

    // skip in SHOW, skip in GAP, skip with pause
    do_reset();
    dwell = 8'd3; run = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 3)  begin chk("skip_mode", mode, 3); chk("skip_done", entry_done, 1); end
      if (k == 6)  chk("skip_gap_ign", mode, 3);
      if (k == 10) chk("gap_len", mode, 3);
      if (k == 11) chk("after_gap", mode, 1);
      if (k == 13) begin chk("skpau_mode", mode, 3); chk("skpau_done", entry_done, 1); end
      skip  = (k == 2 || k == 5 || k == 12);
      pause = (k == 12);
    end

    // dwell 0, dwell change mid-entry, run drop in GAP, reset in SHOW
    do_reset();
    dwell = 8'd0; run = 1'b1;
    for (int k = 1; k <= 43; k++) begin
      @(negedge clk);
      if (k == 4)  chk("d0_show", mode, 0);
      if (k == 5)  chk("d0_gap", mode, 3);
      if (k == 16) chk("d0_e1", mode, 1);
      if (k == 17) chk("d0_e1_end", mode, 3);
      if (k == 32) chk("d2_show", mode, 2);
      if (k == 33) chk("d2_gap", mode, 3);
      if (k == 36) begin
        chk("stop_mode", mode, 3); chk("stop_idx", idx, 0);
        chk("stop_busy", busy, 0); chk("stop_done", entry_done, 0);
      end
      if (k == 38) begin chk("rerun_mode", mode, 0); chk("rerun_idx", idx, 0); end
      if (k == 41) begin
        chk("srst_mode", mode, 3); chk("srst_busy", busy, 0); chk("srst_tick", tick, 0);
      end
      if (k == 42) chk("post_rst", mode, 0);
      if (k == 14) dwell = 8'd2;
      run = !(k == 35 || k == 36);
      rst = (k == 40);
    end

    // random stimulus, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 399) == 0);
      run   = ($urandom_range(0, 99) != 0);
      pause = ($urandom_range(0, 9) == 0);
      skip  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 19) == 0) dwell = 8'($urandom_range(0, 4));
    end
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
